// File: rtl/data_recv.sv
// data_recv: serial byte receiver, 1 start + 8 data (LSB first) + 1 stop, mid-bit sampling.
// Build option PARITY_RX_EN adds an even-parity bit between data and stop (parity_err pulse).
module data_recv #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef PARITY_RX_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_perr;

    state_t        w_state_nxt;
    logic [CW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_ferr_nxt;
    logic          w_perr_nxt;
    logic          w_fall;
    logic          w_par_fail;

    // Only a high->low transition of the synchronised line starts a frame,
    // so a line stuck low (break) never re-triggers.
    assign w_fall = r_prev & ~r_sync2;

`ifdef PARITY_RX_EN
    logic r_par_bad;
    logic w_par_bad_nxt;
    assign w_par_fail = r_par_bad;
`else
    assign w_par_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

`ifdef PARITY_RX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad <= 1'b0;
        end else begin
            r_par_bad <= w_par_bad_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
`ifdef PARITY_RX_EN
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Half-bit check rejects short low glitches on an idle line.
                if (r_baud == HALF_M1) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef PARITY_RX_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_RX_EN
            S_PARITY: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt    = '0;
                    w_par_bad_nxt = ^{r_shift, r_sync2};
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    if (!r_sync2) begin
                        w_ferr_nxt = 1'b1;
                    end else if (w_par_fail) begin
                        w_perr_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_recv.sv
// Bench for data_recv: directed link scenarios plus random frames, checked against an
// event-level model (expected pulse kind and data_out per frame).
`timescale 1ns/1ps
module tb_data_recv;

    localparam int C = 16;
`ifdef PARITY_RX_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    data_recv #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned t_fall = 0;

    // Event word: {kind, data_out}; kind 1 = valid, 2 = frame_err, 3 = parity_err.
    logic [9:0]  obs_q[$];
    int unsigned obs_t[$];
    logic [9:0]  exp_q[$];
    logic [7:0]  last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (valid || frame_err || parity_err) begin
            chk("pulses exclusive", 32'(int'(valid) + int'(frame_err) + int'(parity_err)), 32'd1);
            chk("no pulse during rst", 32'(rst), 32'd0);
            if (valid)          obs_q.push_back({2'd1, data_out});
            else if (frame_err) obs_q.push_back({2'd2, data_out});
            else                obs_q.push_back({2'd3, data_out});
            obs_t.push_back(cyc);
        end
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        t_fall = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (PAR) send_bit(^b ^ par_flip);
        send_bit(stop_v);
    endtask

    // Reference outcome of one frame, straight from the link rules.
    task automatic expect_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        if (!stop_v) begin
            exp_q.push_back({2'd2, last_good});
        end else if (PAR && par_flip) begin
            exp_q.push_back({2'd3, last_good});
        end else begin
            exp_q.push_back({2'd1, b});
            last_good = b;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        expect_frame(b, stop_v, par_flip);
        send_frame(b, stop_v, par_flip);
    endtask

    task automatic idle(input int bits);
        rxd = 1'b1;
        repeat (bits * C) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, " event"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, " data_out"}, 32'(data_out), 32'(last_good));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  rb;
        logic        rs;
        logic        rp;
        int unsigned lat;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst data_out", 32'(data_out), 32'h00);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst frame_err", 32'(frame_err), 32'd0);
        chk("rst parity_err", 32'(parity_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single frame with latency measurement from the pin falling edge.
        frame(8'hA5, 1'b1, 1'b0);
        idle(2);
        chk("A5 one event", 32'(obs_t.size()), 32'd1);
        if (obs_t.size() > 0) begin
            lat = obs_t[0] - t_fall;
            chk("A5 latency window", 32'((lat + 1 >= 9 * C + C / 2 + 3) && (lat <= 9 * C + C / 2 + 4 + (PAR ? C : 0))), 32'd1);
        end
        compare("A5");

        // Back-to-back, no idle gap between stop and next start.
        frame(8'h00, 1'b1, 1'b0);
        frame(8'hFF, 1'b1, 1'b0);
        frame(8'h3C, 1'b1, 1'b0);
        idle(2);
        compare("b2b");

        // Four-cycle glitch on an idle line.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch seen busy", 32'(busy), 32'd1);
        repeat (6) @(negedge clk);
        chk("glitch idle by 12", 32'(busy), 32'd0);
        idle(12);
        compare("glitch");

        // Bad stop followed by a long break, then a clean frame.
        frame(8'h5A, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40 * C) @(negedge clk);
        idle(2);
        compare("break");
        frame(8'h11, 1'b1, 1'b0);
        idle(2);
        compare("after break");

        // Reset in the middle of bit 4; the transmitter shares rst, so the line returns to idle.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'hC3 >> i) & 8'h01));
        rxd = 1'b0;
        repeat (C / 2) @(negedge clk);
        chk("mid-frame busy", 32'(busy), 32'd1);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        chk("post-rst data_out", 32'(data_out), 32'h00);
        chk("post-rst busy", 32'(busy), 32'd0);
        idle(12);
        compare("reset");
        frame(8'h7E, 1'b1, 1'b0);
        idle(2);
        compare("after reset");

        if (PAR) begin
            frame(8'h03, 1'b1, 1'b0);
            idle(1);
            frame(8'h03, 1'b1, 1'b1);
            idle(2);
            compare("parity");
        end

        // Random frames with random gaps; a bad stop needs the line high again before a new start.
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            rp = PAR ? logic'($urandom_range(0, 3) == 0) : 1'b0;
            frame(rb, rs, rp);
            rxd = 1'b1;
            repeat ($urandom_range(0, 2 * C) + (rs ? 0 : C)) @(negedge clk);
        end
        idle(2);
        compare("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
